// File: rtl/dot_accel_if.sv
// Avalon-MM bus bundle used for both the CPU control port and the SDRAM master port.
interface dot_accel_if #(
   parameter int ADDR_W = 32
) ();
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              readdatavalid;
   logic              waitrequest;

   modport master (output address, read, write, writedata,
                   input  readdata, readdatavalid, waitrequest);
   modport slave  (input  address, read, write, writedata,
                   output readdata, waitrequest);
endinterface

// File: rtl/dot_accel.sv
// Q16.16 dot-product accelerator: fetches bias, weights and activations over an
// Avalon-MM master, accumulates, applies optional ReLU and writes one result.
module dot_accel (
   input  logic        clk,
   input  logic        rst_n,
   dot_accel_if.slave  csr,
   dot_accel_if.master mem
);
   typedef enum logic [2:0] {IDLE, RD_BIAS, RD_W, RD_A, MAC, WR_OUT} state_t;

   state_t      state_q;
   logic [31:0] bias_ptr_q, w_ptr_q, a_ptr_q, out_ptr_q, len_q;
   logic        relu_q;
   logic [31:0] acc_q, i_q, bias_q, w_q, a_q;
   logic        rd_q, wr_q;
   logic [31:0] addr_q, wdata_q;

   logic        busy;
   logic        rd_done;
   logic [31:0] mac_sum_d, i_nxt_d, rdata_d;

   function automatic logic [31:0] q16_mul(input logic signed [31:0] x,
                                           input logic signed [31:0] y);
      logic signed [63:0] p;
      p = 64'(x) * 64'(y);
      return p[47:16];
   endfunction

   function automatic logic [31:0] out_val(input logic [31:0] acc,
                                           input logic [31:0] bias,
                                           input logic        relu);
      logic [31:0] r;
      r = acc + bias;
      if (relu && r[31]) r = '0;
      return r;
   endfunction

   assign busy      = (state_q != IDLE);
   // Data only counts once the request has been accepted; stray beats elsewhere are ignored.
   assign rd_done   = !rd_q && mem.readdatavalid;
   assign mac_sum_d = acc_q + q16_mul(w_q, a_q);
   assign i_nxt_d   = i_q + 32'd1;

   always_comb begin
      rdata_d = '0;
      case (csr.address)
         4'd0:    rdata_d = {31'd0, busy};
         4'd1:    rdata_d = bias_ptr_q;
         4'd2:    rdata_d = w_ptr_q;
         4'd3:    rdata_d = a_ptr_q;
         4'd4:    rdata_d = out_ptr_q;
         4'd5:    rdata_d = len_q;
         4'd7:    rdata_d = {31'd0, relu_q};
         default: rdata_d = '0;
      endcase
   end

   assign csr.readdata    = rdata_d;
   assign csr.waitrequest = busy & (csr.read | csr.write);

   assign mem.address   = addr_q;
   assign mem.read      = rd_q;
   assign mem.write     = wr_q;
   assign mem.writedata = wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bias_ptr_q <= '0;
         w_ptr_q    <= '0;
         a_ptr_q    <= '0;
         out_ptr_q  <= '0;
         len_q      <= '0;
         relu_q     <= 1'b0;
         acc_q      <= '0;
         i_q        <= '0;
         bias_q     <= '0;
         w_q        <= '0;
         a_q        <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         if (rd_q && !mem.waitrequest) rd_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (csr.write) begin
                  case (csr.address)
                     4'd0: begin
                        acc_q   <= '0;
                        i_q     <= '0;
                        rd_q    <= 1'b1;
                        addr_q  <= bias_ptr_q;
                        state_q <= RD_BIAS;
                     end
                     4'd1:    bias_ptr_q <= csr.writedata;
                     4'd2:    w_ptr_q    <= csr.writedata;
                     4'd3:    a_ptr_q    <= csr.writedata;
                     4'd4:    out_ptr_q  <= csr.writedata;
                     4'd5:    len_q      <= csr.writedata;
                     4'd7:    relu_q     <= csr.writedata[0];
                     default: ;
                  endcase
               end
            end
            RD_BIAS: begin
               if (rd_done) begin
                  bias_q <= mem.readdata;
                  if (len_q == 32'd0) begin
                     wr_q    <= 1'b1;
                     addr_q  <= out_ptr_q;
                     wdata_q <= out_val(acc_q, mem.readdata, relu_q);
                     state_q <= WR_OUT;
                  end else begin
                     rd_q    <= 1'b1;
                     addr_q  <= w_ptr_q + (i_q << 2);
                     state_q <= RD_W;
                  end
               end
            end
            RD_W: begin
               if (rd_done) begin
                  w_q     <= mem.readdata;
                  rd_q    <= 1'b1;
                  addr_q  <= a_ptr_q + (i_q << 2);
                  state_q <= RD_A;
               end
            end
            RD_A: begin
               if (rd_done) begin
                  a_q     <= mem.readdata;
                  state_q <= MAC;
               end
            end
            MAC: begin
               acc_q <= mac_sum_d;
               if (i_nxt_d == len_q) begin
                  wr_q    <= 1'b1;
                  addr_q  <= out_ptr_q;
                  wdata_q <= out_val(mac_sum_d, bias_q, relu_q);
                  state_q <= WR_OUT;
               end else begin
                  i_q     <= i_nxt_d;
                  rd_q    <= 1'b1;
                  addr_q  <= w_ptr_q + (i_nxt_d << 2);
                  state_q <= RD_W;
               end
            end
            WR_OUT: begin
               if (!mem.waitrequest) begin
                  wr_q    <= 1'b0;
                  addr_q  <= '0;
                  wdata_q <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dot_accel.sv
// Scoreboard bench for dot_accel with a randomly stalling SDRAM responder.
module tb_dot_accel;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dot_accel_if #(.ADDR_W(4))  csr ();
   dot_accel_if #(.ADDR_W(32)) mem ();

   dot_accel dut (.clk(clk), .rst_n(rst_n), .csr(csr), .mem(mem));

   typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;
   exp_t        sb[$];
   logic [31:0] mem_model [logic [31:0]];
   logic [31:0] wv [16];
   logic [31:0] av [16];

   int n_checks = 0;
   int n_errs   = 0;
   int n_rd_req = 0;
   int n_rd_acc = 0;
   int n_wr     = 0;
   int outstanding = 0;
   int rd0, wr0, req0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] bias, input int n, input bit relu);
      logic [31:0] acc;
      logic [31:0] r;
      longint      p;
      acc = '0;
      for (int k = 0; k < n; k++) begin
         p   = longint'($signed(wv[k])) * longint'($signed(av[k]));
         acc = acc + p[47:16];
      end
      r = acc + bias;
      if (relu && r[31]) r = '0;
      return r;
   endfunction

   // SDRAM responder: random accept stalls (0-5) and read latency (1-8), protocol checks.
   initial begin
      logic        prev_act;
      logic        prev_rd;
      logic [31:0] prev_addr, prev_data, lat_data;
      int          stall, lat;
      exp_t        e;
      prev_act = 1'b0; prev_rd = 1'b0; prev_addr = '0; prev_data = '0; lat_data = '0;
      stall = 0; lat = 0;
      mem.waitrequest = 1'b0; mem.readdatavalid = 1'b0; mem.readdata = '0;
      forever begin
         @(negedge clk);
         mem.readdatavalid = 1'b0;
         if (lat > 0) begin
            lat--;
            if (lat == 0) begin
               mem.readdatavalid = 1'b1;
               mem.readdata      = lat_data;
               outstanding--;
            end
         end
         if (mem.read || mem.write) begin
            check("rd_wr_excl", 32'(mem.read & mem.write), 32'd0);
            if (prev_act) begin
               check("stable_addr", mem.address, prev_addr);
               check("stable_strb", 32'(mem.read), 32'(prev_rd));
               if (mem.write) check("stable_wdata", mem.writedata, prev_data);
            end else begin
               stall = $urandom_range(0, 5);
               if (mem.read) n_rd_req++;
            end
            prev_addr = mem.address; prev_data = mem.writedata; prev_rd = mem.read;
            if (stall > 0) begin
               mem.waitrequest = 1'b1;
               stall--;
               prev_act = 1'b1;
            end else begin
               mem.waitrequest = 1'b0;
               prev_act = 1'b0;
               if (mem.read) begin
                  check("one_outstanding", outstanding, 32'd0);
                  outstanding++;
                  n_rd_acc++;
                  lat = $urandom_range(1, 8);
                  lat_data = mem_model.exists(mem.address) ? mem_model[mem.address] : 32'hBAD0_BAD0;
               end else begin
                  n_wr++;
                  check("wr_expected", 32'(sb.size() != 0), 32'd1);
                  if (sb.size() != 0) begin
                     e = sb.pop_front();
                     check("wr_addr", mem.address, e.addr);
                     check("wr_data", mem.writedata, e.data);
                  end
               end
            end
         end else begin
            if (prev_act && rst_n) check("strobe_held", 32'(mem.read | mem.write), 32'd1);
            prev_act = 1'b0;
            mem.waitrequest = 1'b0;
         end
      end
   end

   task automatic csr_write(input logic [3:0] a, input logic [31:0] d, output int stalls);
      stalls = 0;
      @(negedge clk);
      csr.address = a; csr.writedata = d; csr.write = 1'b1;
      #1;
      while (csr.waitrequest && stalls < 5000) begin
         @(negedge clk); #1;
         stalls++;
      end
      check("csr_wr_timeout", 32'(stalls < 5000), 32'd1);
      @(posedge clk); #1;
      csr.write = 1'b0;
   endtask

   task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      csr.address = a; csr.read = 1'b1;
      #1;
      d = csr.readdata;
      check("csr_rd_nowait", 32'(csr.waitrequest), 32'd0);
      @(posedge clk); #1;
      csr.read = 1'b0;
   endtask

   task automatic run_job(input logic [31:0] bp, input logic [31:0] wp, input logic [31:0] ap,
                          input logic [31:0] op, input logic [31:0] bias, input int n, input bit relu);
      int   s;
      exp_t e;
      mem_model[bp] = bias;
      for (int k = 0; k < n; k++) begin
         mem_model[wp + 32'(4 * k)] = wv[k];
         mem_model[ap + 32'(4 * k)] = av[k];
      end
      csr_write(4'd1, bp, s);
      csr_write(4'd2, wp, s);
      csr_write(4'd3, ap, s);
      csr_write(4'd4, op, s);
      csr_write(4'd5, 32'(n), s);
      csr_write(4'd7, {31'd0, relu}, s);
      e.addr = op; e.data = model(bias, n, relu);
      sb.push_back(e);
      rd0 = n_rd_acc; wr0 = n_wr; req0 = n_rd_req;
      csr_write(4'd0, 32'd1, s);
   endtask

   task automatic wait_writes(input int target, input int budget);
      int c = 0;
      while (n_wr < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("done_in_time", 32'(n_wr >= target), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mread"},  32'(mem.read), 32'd0);
      check({tag, "_mwrite"}, 32'(mem.write), 32'd0);
      check({tag, "_maddr"},  mem.address, 32'd0);
      check({tag, "_mwdata"}, mem.writedata, 32'd0);
      check({tag, "_swait"},  32'(csr.waitrequest), 32'd0);
      check({tag, "_srdata"}, csr.readdata, 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          s;
      exp_t        e;
      csr.address = '0; csr.read = 1'b0; csr.write = 1'b0; csr.writedata = '0;
      csr.readdatavalid = 1'b0;

      // reset state, with a slave read of the length register held during reset
      #12;
      csr.address = 4'd5; csr.read = 1'b1;
      #1;
      check_reset_outputs("rst0");
      csr.read = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      csr_read(4'd0, d);
      check("status_after_reset", d, 32'd0);

      // basic: w = {1.0, 2.0, -1.0}, a = {0.5, 0.25, 4.0}, bias = 1.0
      wv[0] = 32'h0001_0000; wv[1] = 32'h0002_0000; wv[2] = 32'hFFFF_0000;
      av[0] = 32'h0000_8000; av[1] = 32'h0000_4000; av[2] = 32'h0004_0000;
      run_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h0001_0000, 3, 1'b0);
      wait_writes(wr0 + 1, 2000);
      check("basic_reads", n_rd_acc - rd0, 32'd7);
      csr_read(4'd0, d);
      check("basic_status", d, 32'd0);
      csr_read(4'd5, d);
      check("len_readback", d, 32'd3);
      csr_read(4'd6, d);
      check("unmapped_read", d, 32'd0);

      // same operands with ReLU enabled
      run_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h0001_0000, 3, 1'b1);
      wait_writes(wr0 + 1, 2000);
      csr_read(4'd7, d);
      check("relu_readback", d, 32'd1);

      // N = 0: only the bias is fetched
      run_job(32'h1100, 32'h2000, 32'h3000, 32'h4100, 32'h0003_0000, 0, 1'b0);
      wait_writes(wr0 + 1, 1000);
      check("n0_reads", n_rd_acc - rd0, 32'd1);

      // N = 16 random operands, unaligned pointers
      for (int k = 0; k < 16; k++) begin
         wv[k] = $urandom();
         av[k] = $urandom();
      end
      run_job(32'h8003, 32'h9001, 32'hA002, 32'hB001, $urandom(), 16, 1'b0);
      wait_writes(wr0 + 1, 6000);
      check("n16_reads", n_rd_acc - rd0, 32'd33);
      csr_read(4'd0, d);
      check("n16_status", d, 32'd0);

      // register write while busy stalls until the job completes
      run_job(32'hC000, 32'hC100, 32'hC200, 32'hC300, 32'h0000_1234, 4, 1'b0);
      repeat (5) @(negedge clk);
      csr_write(4'd1, 32'h7000, s);
      check("slave_stalled", 32'(s > 0), 32'd1);
      check("inflight_first", n_wr - wr0, 32'd1);
      mem_model[32'h7000] = 32'h1234_5678;
      csr_write(4'd5, 32'd0, s);
      e.addr = 32'hC300; e.data = 32'h1234_5678;
      sb.push_back(e);
      wr0 = n_wr;
      csr_write(4'd0, 32'd1, s);
      wait_writes(wr0 + 1, 1000);

      // reset during RD_A of i = 2
      for (int k = 0; k < 4; k++) begin
         wv[k] = 32'h0001_0000 + 32'(k);
         av[k] = 32'h0002_0000 - 32'(k);
      end
      run_job(32'hD000, 32'hD100, 32'hD200, 32'hD300, 32'h0001_0000, 4, 1'b0);
      s = 0;
      while ((n_rd_req - req0) < 7 && s < 3000) begin
         @(negedge clk);
         s++;
      end
      check("reached_rd_a2", 32'(n_rd_req - req0), 32'd7);
      #2;
      rst_n = 1'b0;
      csr.address = 4'd5; csr.read = 1'b1;
      #1;
      check_reset_outputs("rst1");
      csr.read = 1'b0;
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("no_write_after_abort", n_wr - wr0, 32'd0);

      wv[0] = 32'h0002_0000; av[0] = 32'h0001_8000;
      run_job(32'hE000, 32'hE100, 32'hE200, 32'hE300, 32'hFFFF_8000, 1, 1'b0);
      wait_writes(wr0 + 1, 1000);
      check("n1_reads", n_rd_acc - rd0, 32'd3);
      csr_read(4'd0, d);
      check("final_status", d, 32'd0);
      check("sb_drained", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
